// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding, width default.
// The LSU_MISALIGNED_EN macro adds the second-beat states used for split accesses.
package lsu_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq0  = 3'd1,
    StWait0 = 3'd2,
    StResp  = 3'd5
`ifdef LSU_MISALIGNED_EN
    ,
    StReq1  = 3'd3,
    StWait1 = 3'd4
`endif
  } lsu_state_e;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    if (store) return f3 inside {F3Byte, F3Half, F3Word};
    return f3 inside {F3Byte, F3Half, F3Word, F3ByteU, F3HalfU};
  endfunction

  // An access is misaligned when it crosses a word boundary.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3Half, F3HalfU: return off == 2'd3;
      F3Word:          return off != 2'd0;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store strobe/data shifting across two words and
// load byte/half selection with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [1:0]        off_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_lo_i,
  input  logic [XLEN-1:0]   rdata_hi_i,
  output logic [XLEN/8-1:0] wstrb_lo_o,
  output logic [XLEN/8-1:0] wstrb_hi_o,
  output logic [XLEN-1:0]   wdata_lo_o,
  output logic [XLEN-1:0]   wdata_hi_o,
  output logic [XLEN-1:0]   rdata_o
);

  localparam int unsigned NB = XLEN / 8;

  logic [NB-1:0]     mask;
  logic [2*NB-1:0]   strb2;
  logic [2*XLEN-1:0] wd2;
  logic [XLEN-1:0]   rd_sel;

  always_comb begin
    mask = '0;
    case (funct3_i[1:0])
      2'b00:   mask = NB'(1);
      2'b01:   mask = NB'(3);
      default: mask = '1;
    endcase
    // Shift into a double-word window; the upper half feeds the second beat.
    strb2  = {{NB{1'b0}}, mask} << off_i;
    wd2    = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
    rd_sel = XLEN'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});

    wstrb_lo_o = strb2[NB-1:0];
    wstrb_hi_o = strb2[2*NB-1:NB];
    wdata_lo_o = wd2[XLEN-1:0];
    wdata_hi_o = wd2[2*XLEN-1:XLEN];

    rdata_o = rd_sel;
    case (funct3_i)
      F3Byte:  rdata_o = {{(XLEN-8){rd_sel[7]}}, rd_sel[7:0]};
      F3Half:  rdata_o = {{(XLEN-16){rd_sel[15]}}, rd_sel[15:0]};
      F3ByteU: rdata_o = {{(XLEN-8){1'b0}}, rd_sel[7:0]};
      F3HalfU: rdata_o = {{(XLEN-16){1'b0}}, rd_sel[15:0]};
      default: rdata_o = rd_sel;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit issuing word beats to a data cache.
// LSU_MISALIGNED_EN: split word-crossing accesses into two beats instead of faulting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_base,
  input  logic [11:0]       req_offset,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB = XLEN / 8;

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            store_q, store_d;
  logic            err_q, err_d;

  logic [XLEN-1:0] ea, word_addr, rdata_lo, ld_result, wdata_lo, wdata_hi;
  logic [NB-1:0]   wstrb_lo, wstrb_hi;
  logic            second_beat;

`ifdef LSU_MISALIGNED_EN
  logic            split_q, split_d;
  logic [XLEN-1:0] rdata0_q, rdata0_d;
  assign second_beat = (state_q == StReq1);
  assign rdata_lo    = split_q ? rdata0_q : mem_rdata;
`else
  assign second_beat = 1'b0;
  assign rdata_lo    = mem_rdata;
`endif

  assign ea        = req_base + {{(XLEN-12){req_offset[11]}}, req_offset};
  assign word_addr = {addr_q[XLEN-1:2], 2'b00};
  assign req_ready = (state_q == StIdle);

  lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .off_i     (addr_q[1:0]),
    .funct3_i  (funct3_q),
    .wdata_i   (wdata_q),
    .rdata_lo_i(rdata_lo),
    .rdata_hi_i(mem_rdata),
    .wstrb_lo_o(wstrb_lo),
    .wstrb_hi_o(wstrb_hi),
    .wdata_lo_o(wdata_lo),
    .wdata_hi_o(wdata_hi),
    .rdata_o   (ld_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      funct3_q   <= '0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef LSU_MISALIGNED_EN
      split_q    <= 1'b0;
      rdata0_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      funct3_q   <= funct3_d;
      store_q    <= store_d;
      err_q      <= err_d;
`ifdef LSU_MISALIGNED_EN
      split_q    <= split_d;
      rdata0_q   <= rdata0_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    funct3_d   = funct3_q;
    store_d    = store_q;
    err_d      = err_q;
`ifdef LSU_MISALIGNED_EN
    split_d    = split_q;
    rdata0_d   = rdata0_q;
`endif
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d     = ea;
          wdata_d    = req_wdata;
          funct3_d   = req_funct3;
          store_d    = req_store;
          rsp_data_d = '0;
          err_d      = 1'b0;
          state_d    = StReq0;
`ifdef LSU_MISALIGNED_EN
          split_d    = f3_misaligned(req_funct3, ea[1:0]);
          if (!f3_legal(req_store, req_funct3)) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
`else
          if (!f3_legal(req_store, req_funct3) || f3_misaligned(req_funct3, ea[1:0])) begin
            err_d   = 1'b1;
            state_d = StResp;
          end
`endif
        end
      end
      StReq0: if (mem_ready) state_d = StWait0;
      StWait0: begin
        if (mem_rvalid) begin
`ifdef LSU_MISALIGNED_EN
          if (split_q) begin
            rdata0_d = mem_rdata;
            state_d  = StReq1;
          end else begin
            rsp_data_d = store_q ? '0 : ld_result;
            state_d    = StResp;
          end
`else
          rsp_data_d = store_q ? '0 : ld_result;
          state_d    = StResp;
`endif
        end
      end
`ifdef LSU_MISALIGNED_EN
      StReq1: if (mem_ready) state_d = StWait1;
      StWait1: begin
        if (mem_rvalid) begin
          rsp_data_d = store_q ? '0 : ld_result;
          state_d    = StResp;
        end
      end
`endif
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side outputs are zero outside the request states, so reset clears them.
  always_comb begin
    mem_valid = (state_q == StReq0) || second_beat;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (mem_valid) begin
      mem_addr = second_beat ? word_addr + XLEN'(4) : word_addr;
      mem_we   = store_q;
      if (store_q) begin
        mem_wstrb = second_beat ? wstrb_hi : wstrb_lo;
        mem_wdata = second_beat ? wdata_hi : wdata_lo;
      end
    end
    rsp_valid = (state_q == StResp);
    rsp_data  = rsp_valid ? rsp_data_q : '0;
    rsp_err   = rsp_valid & err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and
// beats; a responder checks beats and a monitor checks responses and their timing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_base = '0;
  logic [11:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(
    .XLEN(32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_funct3(req_funct3),
    .req_base  (req_base),
    .req_offset(req_offset),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [3:0]  s;
    logic [31:0] wd;
    logic [31:0] rd;
  } beat_t;

  rsp_t  rsp_q[$];
  beat_t beat_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    stall = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin : mon_rsp
    rsp_t e;
    if (rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
  end

  // Memory responder: checks every cycle a beat is presented, so stalls test stability.
  initial begin : responder
    beat_t b;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend_d;
        pend       = 1'b0;
      end
      mem_ready = 1'b1;
      if (mem_valid) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", {31'b0, mem_valid}, 32'd0);
        end else begin
          b = beat_q[0];
          chk("beat_addr", mem_addr, b.a);
          chk("beat_we", {31'b0, mem_we}, {31'b0, b.we});
          chk("beat_wstrb", {28'b0, mem_wstrb}, {28'b0, b.s});
          if (b.we) chk("beat_wdata", mem_wdata, b.wd);
          if (stall > 0) begin
            mem_ready = 1'b0;
            stall--;
          end else begin
            void'(beat_q.pop_front());
            pend   = 1'b1;
            pend_d = b.rd;
          end
        end
      end
    end
  end

  task automatic exp_beat(input logic [31:0] a, input logic we, input logic [3:0] s,
                          input logic [31:0] wd, input logic [31:0] rd);
    beat_t b;
    b.a = a; b.we = we; b.s = s; b.wd = wd; b.rd = rd;
    beat_q.push_back(b);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] off, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // lat: cycles from accept to rsp_valid (1 = the cycle right after the accept edge).
  task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] base,
                     input logic [11:0] off, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e, input int lat);
    rsp_t r;
    int   k;
    issue(st, f3, base, off, wd);
    r.d = exp_d; r.e = exp_e; r.cyc = cyc + lat - 1;
    rsp_q.push_back(r);
    k = 0;
    while (rsp_q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rsp_q.size() != 0) begin
      chk("rsp_timeout", rsp_q.size(), 32'd0);
      rsp_q.delete();
    end
    chk("beats_left", beat_q.size(), 32'd0);
    beat_q.delete();
    stall = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: no finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k;
    repeat (3) @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

    // SW 0x104
    exp_beat(32'h104, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0);
    run(1'b1, 3'b010, 32'h100, 12'h004, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    // LB / LBU at 0x203
    exp_beat(32'h200, 1'b0, 4'b0000, 32'h0, 32'h80FFFFFF);
    run(1'b0, 3'b000, 32'h200, 12'h003, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    exp_beat(32'h200, 1'b0, 4'b0000, 32'h0, 32'h80FFFFFF);
    run(1'b0, 3'b100, 32'h200, 12'h003, 32'h0, 32'h00000080, 1'b0, 3);
    // SH 0x302
    exp_beat(32'h300, 1'b1, 4'b1100, 32'h12340000, 32'h0);
    run(1'b1, 3'b001, 32'h300, 12'h002, 32'h00001234, 32'h0, 1'b0, 3);
    // SB 0x11: upper rs2 bits shift along, strobe masks them
    exp_beat(32'h10, 1'b1, 4'b0010, 32'h3456AB00, 32'h0);
    run(1'b1, 3'b000, 32'h10, 12'h001, 32'h123456AB, 32'h0, 1'b0, 3);
    // LH with negative offset: 0x1000 - 2 = 0xFFE
    exp_beat(32'hFFC, 1'b0, 4'b0000, 32'h0, 32'h9ABC0000);
    run(1'b0, 3'b001, 32'h1000, 12'hFFE, 32'h0, 32'hFFFF9ABC, 1'b0, 3);
    // LHU at 0x20
    exp_beat(32'h20, 1'b0, 4'b0000, 32'h0, 32'h12348001);
    run(1'b0, 3'b101, 32'h20, 12'h000, 32'h0, 32'h00008001, 1'b0, 3);
    // LW at top of address space
    exp_beat(32'hFFFFFFFC, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D);
    run(1'b0, 3'b010, 32'hFFFFFFF0, 12'h00C, 32'h0, 32'hCAFEF00D, 1'b0, 3);
    // Illegal codes: load 011, store 100
    run(1'b0, 3'b011, 32'h800, 12'h000, 32'h0, 32'h0, 1'b1, 1);
    run(1'b1, 3'b100, 32'h800, 12'h000, 32'h0, 32'h0, 1'b1, 1);
    // LW with mem_ready low 3 cycles
    stall = 3;
    exp_beat(32'h600, 1'b0, 4'b0000, 32'h0, 32'h01020304);
    run(1'b0, 3'b010, 32'h600, 12'h000, 32'h0, 32'h01020304, 1'b0, 6);
`ifdef LSU_MISALIGNED_EN
    exp_beat(32'h400, 1'b0, 4'b0000, 32'h0, 32'h44332211);
    exp_beat(32'h404, 1'b0, 4'b0000, 32'h0, 32'h88776655);
    run(1'b0, 3'b010, 32'h400, 12'h001, 32'h0, 32'h55443322, 1'b0, 5);
    exp_beat(32'hFFFFFFFC, 1'b1, 4'b1000, 32'hEF000000, 32'h0);
    exp_beat(32'h00000000, 1'b1, 4'b0001, 32'h000000BE, 32'h0);
    run(1'b1, 3'b001, 32'hFFFFFFFF, 12'h000, 32'h0000BEEF, 32'h0, 1'b0, 5);
`else
    run(1'b0, 3'b010, 32'h400, 12'h001, 32'h0, 32'h0, 1'b1, 1);
    run(1'b1, 3'b001, 32'hFFFFFFFF, 12'h000, 32'h0000BEEF, 32'h0, 1'b1, 1);
`endif

    // Reset in WAIT0 after a 5-cycle stall: no response, outputs cleared.
    stall = 5;
    exp_beat(32'h500, 1'b0, 4'b0000, 32'h0, 32'h11111111);
    issue(1'b0, 3'b010, 32'h500, 12'h000, 32'h0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (mem_valid && k < 20);
    chk("wait0_reached", {31'b0, mem_valid}, 32'd0);
    chk("beat_taken", beat_q.size(), 32'd0);
    beat_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_valid", {31'b0, mem_valid}, 32'd0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_rsp_data", rsp_data, 32'd0);
    chk("mid_rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_post_rst", {31'b0, req_ready}, 32'd1);
    stall = 0;

    // Recovery after abandoned transaction
    exp_beat(32'h700, 1'b0, 4'b0000, 32'h0, 32'h55AA55AA);
    run(1'b0, 3'b010, 32'h700, 12'h000, 32'h0, 32'h55AA55AA, 1'b0, 3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
